// File: rtl/digit_classifier.sv
// Ten-class MNIST logit MAC with argmax; one MAC per cycle, 787 cycles per class.
// Optional per-class score readback under CLASSIFIER_SCORE_DUMP_EN.
module digit_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int NUM_PIXELS  = 784,
  parameter int ACC_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             weights_ready,
  output logic [12:0]      weight_rd_addr,
  input  logic [7:0]       weight_rd_data,
  output logic [3:0]       bias_rd_addr,
  input  logic [31:0]      bias_rd_data,
  output logic [9:0]       pixel_rd_addr,
  input  logic [7:0]       pixel_rd_data,
`ifdef CLASSIFIER_SCORE_DUMP_EN
  input  logic [3:0]       score_rd_addr,
  output logic [ACC_W-1:0] score_rd_data,
`endif
  output logic             busy,
  output logic             done,
  output logic [3:0]       predicted_digit,
  output logic [ACC_W-1:0] max_score
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_BIAS,
    S_MAC,
    S_DRAIN,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam logic [9:0]  LAST_PIX = 10'(NUM_PIXELS - 1);
  localparam logic [3:0]  LAST_CLS = 4'(NUM_CLASSES - 1);
  localparam logic [12:0] STRIDE   = 13'(NUM_PIXELS);

  state_t            state_q, state_d;
  logic [3:0]        cls_q, cls_d;
  logic [12:0]       base_q, base_d;
  logic [12:0]       wt_addr_q, wt_addr_d;
  logic [9:0]        pix_addr_q, pix_addr_d;
  logic [3:0]        bias_addr_q, bias_addr_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  best_q, best_d;
  logic [3:0]        best_idx_q, best_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        pred_q, pred_d;
  logic [ACC_W-1:0]  score_q, score_d;

  logic signed [16:0] prod;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   bias_ext;
  logic               win;

  // Pixel is zero-extended so 255 stays positive in the signed product.
  assign prod = $signed({{9{weight_rd_data[7]}}, weight_rd_data})
              * $signed({9'b0, pixel_rd_data});
  assign prod_ext = ACC_W'(prod);
  assign bias_ext = ACC_W'($signed(bias_rd_data));
  assign win = (cls_q == 4'd0) || ($signed(acc_q) > $signed(best_q));

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    base_d      = base_q;
    wt_addr_d   = wt_addr_q;
    pix_addr_d  = pix_addr_q;
    bias_addr_d = bias_addr_q;
    acc_d       = acc_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pred_d      = pred_q;
    score_d     = score_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && weights_ready) begin
          state_d     = S_LOAD_BIAS;
          cls_d       = 4'd0;
          base_d      = 13'd0;
          bias_addr_d = 4'd0;
          busy_d      = 1'b1;
        end
      end
      S_LOAD_BIAS: begin
        state_d    = S_MAC;
        pix_addr_d = 10'd0;
        wt_addr_d  = base_q;
      end
      S_MAC: begin
        acc_d = (pix_addr_q == 10'd0) ? bias_ext : acc_q + prod_ext;
        if (pix_addr_q == LAST_PIX) begin
          state_d = S_DRAIN;
        end else begin
          pix_addr_d = pix_addr_q + 10'd1;
          wt_addr_d  = wt_addr_q + 13'd1;
        end
      end
      S_DRAIN: begin
        acc_d   = acc_q + prod_ext;
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (win) begin
          best_d     = acc_q;
          best_idx_d = cls_q;
        end
        if (cls_q == LAST_CLS) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pred_d  = win ? cls_q : best_idx_q;
          score_d = win ? acc_q : best_q;
        end else begin
          state_d     = S_LOAD_BIAS;
          cls_d       = cls_q + 4'd1;
          bias_addr_d = cls_q + 4'd1;
          base_d      = base_q + STRIDE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cls_q       <= '0;
      base_q      <= '0;
      wt_addr_q   <= '0;
      pix_addr_q  <= '0;
      bias_addr_q <= '0;
      acc_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pred_q      <= '0;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      base_q      <= base_d;
      wt_addr_q   <= wt_addr_d;
      pix_addr_q  <= pix_addr_d;
      bias_addr_q <= bias_addr_d;
      acc_q       <= acc_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pred_q      <= pred_d;
      score_q     <= score_d;
    end
  end

  assign weight_rd_addr  = wt_addr_q;
  assign pixel_rd_addr   = pix_addr_q;
  assign bias_rd_addr    = bias_addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign predicted_digit = pred_q;
  assign max_score       = score_q;

`ifdef CLASSIFIER_SCORE_DUMP_EN
  logic [ACC_W-1:0] scores_q [NUM_CLASSES];
  logic [ACC_W-1:0] score_rd_q, score_rd_d;

  always_comb begin
    score_rd_d = '0;
    if (32'(score_rd_addr) < NUM_CLASSES) begin
      score_rd_d = scores_q[score_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        scores_q[i] <= '0;
      end
      score_rd_q <= '0;
    end else begin
      if (state_q == S_COMPARE) begin
        scores_q[cls_q] <= acc_q;
      end
      score_rd_q <= score_rd_d;
    end
  end

  assign score_rd_data = score_rd_q;
`endif

endmodule

// File: tb/tb_digit_classifier.sv
// Scoreboarded bench for digit_classifier with behavioural weight/bias/pixel RAMs.
// Covers latency, ties, signed MAC, handshake, mid-run reset, random image.
module tb_digit_classifier;

  localparam int NC = 10;
  localparam int NP = 784;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          weights_ready = 1'b1;
  logic [12:0]   weight_rd_addr;
  logic [7:0]    weight_rd_data;
  logic [3:0]    bias_rd_addr;
  logic [31:0]   bias_rd_data;
  logic [9:0]    pixel_rd_addr;
  logic [7:0]    pixel_rd_data;
  logic          busy;
  logic          done;
  logic [3:0]    predicted_digit;
  logic [AW-1:0] max_score;
`ifdef CLASSIFIER_SCORE_DUMP_EN
  logic [3:0]    score_rd_addr = 4'd0;
  logic [AW-1:0] score_rd_data;
`endif

  digit_classifier #(
    .NUM_CLASSES(NC),
    .NUM_PIXELS (NP),
    .ACC_W      (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .weights_ready  (weights_ready),
    .weight_rd_addr (weight_rd_addr),
    .weight_rd_data (weight_rd_data),
    .bias_rd_addr   (bias_rd_addr),
    .bias_rd_data   (bias_rd_data),
    .pixel_rd_addr  (pixel_rd_addr),
    .pixel_rd_data  (pixel_rd_data),
`ifdef CLASSIFIER_SCORE_DUMP_EN
    .score_rd_addr  (score_rd_addr),
    .score_rd_data  (score_rd_data),
`endif
    .busy           (busy),
    .done           (done),
    .predicted_digit(predicted_digit),
    .max_score      (max_score)
  );

  always #5 clk = ~clk;

  logic [7:0]  wmem [NC*NP];
  logic [31:0] bmem [NC];
  logic [7:0]  pmem [NP];

  always @(posedge clk) begin
    weight_rd_data <= (32'(weight_rd_addr) < NC*NP) ? wmem[weight_rd_addr] : 8'h00;
    bias_rd_data   <= (32'(bias_rd_addr) < NC) ? bmem[bias_rd_addr] : 32'h0;
    pixel_rd_data  <= (32'(pixel_rd_addr) < NP) ? pmem[pixel_rd_addr] : 8'h00;
  end

  typedef struct packed {
    logic [3:0]  d;
    logic [31:0] s;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_all(input logic [7:0] w, input logic [31:0] b,
                         input logic [7:0] p);
    for (int i = 0; i < NC*NP; i++) wmem[i] = w;
    for (int i = 0; i < NC; i++) bmem[i] = b;
    for (int i = 0; i < NP; i++) pmem[i] = p;
  endtask

  function automatic exp_t model();
    int         acc;
    int         best;
    logic [3:0] bi;
    best = 0;
    bi   = 4'd0;
    for (int c = 0; c < NC; c++) begin
      acc = int'(bmem[c]);
      for (int p = 0; p < NP; p++) begin
        acc += int'($signed(wmem[c*NP+p])) * int'(pmem[p]);
      end
      if (c == 0 || acc > best) begin
        best = acc;
        bi   = 4'(c);
      end
    end
    return {bi, 32'(best)};
  endfunction

  // mode 0: plain run, 1: extra start while busy, 2: reset at cycle 4000
  task automatic run(input string tag, input exp_t e, input int mode);
    bit   seen;
    bit   late_done;
    exp_t g;
    int   cy;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    cy = 1;
    check({tag, "_busy_c1"}, 64'(busy), 1);
    while (!seen && cy < 9000) begin
      if (mode == 1 && cy == 2000) start = 1'b1;
      if (mode == 2 && cy == 4000) rst = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cy++;
      if (mode == 2 && cy == 4001) begin
        check({tag, "_rst_busy"}, 64'(busy), 0);
        check({tag, "_rst_done"}, 64'(done), 0);
        check({tag, "_rst_digit"}, 64'(predicted_digit), 0);
        check({tag, "_rst_score"}, $signed(max_score), 0);
        rst = 1'b0;
        sb.delete();
        late_done = 1'b0;
        repeat (50) begin
          @(posedge clk);
          #1;
          if (done || busy) late_done = 1'b1;
        end
        check({tag, "_rst_quiet"}, 64'(late_done), 0);
        return;
      end
      if (cy == 7870) check({tag, "_busy_c7870"}, 64'(busy), 1);
      if (done) begin
        seen = 1'b1;
        check({tag, "_done_cycle"}, 64'(cy), 7871);
        check({tag, "_busy_done"}, 64'(busy), 0);
        if (sb.size() > 0) begin
          g = sb.pop_front();
          check({tag, "_digit"}, 64'(predicted_digit), 64'(g.d));
          check({tag, "_score"}, $signed(max_score), $signed(g.s));
        end
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(done), 0);
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 1);
  endtask

  initial begin
    set_all(8'h00, 32'h0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_digit", 64'(predicted_digit), 0);
    check("rst_score", $signed(max_score), 0);
    check("rst_waddr", 64'(weight_rd_addr), 0);
    check("rst_baddr", 64'(bias_rd_addr), 0);
    check("rst_paddr", 64'(pixel_rd_addr), 0);
    rst = 1'b0;

    weights_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("no_ready_busy", 64'(busy), 0);
      @(posedge clk);
      #1;
    end
    weights_ready = 1'b1;

    bmem[7] = 32'd100;
    run("s1", {4'd7, 32'd100}, 1);

    set_all(8'h00, 32'h0, 8'h00);
    run("s2", {4'd0, 32'd0}, 0);

    set_all(8'h00, 32'h0, 8'hFF);
    for (int p = 0; p < NP; p++) wmem[3*NP+p] = 8'd1;
    run("s3", {4'd3, 32'd199920}, 0);

`ifdef CLASSIFIER_SCORE_DUMP_EN
    @(negedge clk);
    score_rd_addr = 4'd3;
    @(posedge clk);
    #1;
    check("dump3", $signed(score_rd_data), 199920);
    score_rd_addr = 4'd0;
    @(posedge clk);
    #1;
    check("dump0", $signed(score_rd_data), 0);
`endif

    set_all(8'h80, 32'h0, 8'hFF);
    for (int p = 0; p < NP; p++) wmem[9*NP+p] = 8'hFF;
    run("s4", {4'd9, 32'hFFFC_F310}, 0);

    for (int i = 0; i < NC*NP; i++) wmem[i] = 8'($urandom);
    for (int i = 0; i < NP; i++) pmem[i] = 8'($urandom);
    for (int i = 0; i < NC; i++) bmem[i] = 32'($urandom_range(0, 400000)) - 32'd200000;
    run("rnd", model(), 0);

    set_all(8'h00, 32'h0, 8'h00);
    bmem[7] = 32'd100;
    run("abort", {4'd7, 32'd100}, 2);
    run("s1b", {4'd7, 32'd100}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/digit_classifier.md
# digit_classifier

Inference stage for the MNIST softmax-regression design: on `start`, computes the ten class logits `bias[c] + Σ weight[c][p]·pixel[p]` over 784 pixels and outputs the argmax digit. It sits directly downstream of the weight loader, reading its synchronous weight and bias ports. It reads the image through an equivalent synchronous pixel port from the image buffer. Softmax itself is not evaluated, because argmax of the logits gives the same result.

## Interface
- `NUM_CLASSES`, default 10. Number of output classes.
- `NUM_PIXELS`, default 784. Pixels per image.
- `ACC_W`, default 32. Accumulator and score width.
- `clk` in 1. System clock.
- `rst` in 1. Reset, synchronous, active-high.
- `start` in 1. Request one classification. Accepted only in IDLE when `weights_ready`=1.
- `weights_ready` in 1. Connected to the loader's `transfer_done`.
- `weight_rd_addr` out 13. Address = c·784+p. Data returns 1 cycle later.
- `weight_rd_data` in 8. Signed weight.
- `bias_rd_addr` out 4. Class index. Data returns 1 cycle later.
- `bias_rd_data` in 32. Signed bias.
- `pixel_rd_addr` out 10. Pixel index 0..783. Data returns 1 cycle later.
- `pixel_rd_data` in 8. Unsigned pixel.
- `busy` out 1. High from the cycle after `start` is accepted until DONE.
- `done` out 1. One-cycle pulse when the result is valid.
- `predicted_digit` out 4. Argmax class. Held until the next `done`.
- `max_score` out ACC_W. Winning logit, signed. Held until the next `done`.

## Operation
- States: IDLE, LOAD_BIAS, MAC, DRAIN, COMPARE, DONE.
- **IDLE**
  - On `start` && `weights_ready`: class←0, base←0, go to LOAD_BIAS.
  - `start` is ignored otherwise, including whenever `busy`=1.
- **LOAD_BIAS**: drive `bias_rd_addr`=class. Go to MAC with p←0.
- **MAC** (784 cycles, p=0..783)
  - Drive `pixel_rd_addr`=p and `weight_rd_addr`=base+p. The address comes from a running counter, with no multiplier.
  - First MAC cycle: acc←`bias_rd_data`.
  - Later cycles: acc←acc+prod, where prod is for the previous p.
  - After p=783, go to DRAIN.
- **DRAIN**: acc←acc+prod(783). Go to COMPARE.
- **COMPARE**
  - If class==0 or acc>best (signed, strict): best←acc, best_idx←class. Ties therefore keep the lowest index.
  - If class==NUM_CLASSES-1: go to DONE.
  - Else: class++, base+=784, go to LOAD_BIAS.
- **DONE**: `done`=1 for this cycle only, `busy`=0, then return to IDLE.
  - `predicted_digit`/`max_score` are loaded on the edge entering DONE.
- **Arithmetic**
  - prod = signed(weight) × signed({1'b0,pixel}), 17-bit signed, sign-extended to ACC_W.
  - acc wraps in two's complement; there is no saturation.
- Read addresses are don't-care outside LOAD_BIAS/MAC. They are held at their last value.
- `rst` at any time, including mid-computation: immediately back to IDLE with every output at its reset value. Partial results are discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `predicted_digit`=0, `max_score`=0, all read addresses 0.
- Per class: 1 (LOAD_BIAS) + 784 (MAC) + 1 (DRAIN) + 1 (COMPARE) = 787 cycles.
- If `start` is sampled at edge 0:
  - `busy`=1 during cycles 1..7870.
  - `done`=1 in cycle 7871.
  - `start` is accepted again from cycle 7872 (IDLE).
- Throughput is one MAC per cycle, with no stalls. All upstream ports have a fixed 1-cycle read latency.

## Configuration
- Macro `CLASSIFIER_SCORE_DUMP_EN`.
- **Defined**:
  - Adds ports `score_rd_addr` in 4 and `score_rd_data` out ACC_W.
  - These front a 10-entry register file, reset to 0. Entry c is written in COMPARE for class c. Reads are synchronous with 1-cycle latency.
- **Undefined**: these ports and the storage are absent. Only the argmax result is available.

## Test plan
- Basic argmax and latency:
  - Stimulus: weights all 0, biases 0 except bias[7]=100, image all 0, start at edge 0.
  - Required: `done` in cycle 7871, `predicted_digit`=7, `max_score`=100.
- All zero (tie):
  - Stimulus: weights, biases and image all 0.
  - Required: `predicted_digit`=0, `max_score`=0 (lowest index wins the tie).
- Positive MAC path:
  - Stimulus: weight[3][p]=1 for all p, other weights 0, biases 0, pixels 255.
  - Required: `predicted_digit`=3, `max_score`=199920.
- Negative values, signedness, full accumulation:
  - Stimulus: classes 0..8 weights -128, class 9 weights -1, biases 0, pixels 255.
  - Required: `predicted_digit`=9, `max_score`=-199920.
- Handshake and reset:
  - `start` with `weights_ready`=0: `busy` stays 0.
  - `start` pulsed at cycle 2000 while busy: ignored, `done` still at 7871.
  - `rst` at cycle 4000: `busy`=0 next cycle, no `done`. A subsequent run of scenario 1 is correct.
- With `CLASSIFIER_SCORE_DUMP_EN`, after scenario 3:
  - `score_rd_addr`=3 gives 199920 one cycle later.
  - `score_rd_addr`=0 gives 0 one cycle later.
